// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Produces sequential byte addresses and applies stall, branch/jump redirect,
// trap vectoring and halt/resume. It also keeps a one-stage fetch-to-decode
// PC register and rejects redirect targets that are not instruction-aligned.
module pc_gen #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INC          = 4,
    parameter int unsigned IALIGN_BITS  = 2,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  trap_valid,
    input  logic                  halt,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_next_seq,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] pc_d,
    output logic                  pc_d_valid,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] bad_addr,
    output logic                  halted
);

    // Vectors and masks resized to the address width. An IALIGN_BITS of 0
    // gives an all-zero mask, so every target is accepted.
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] TRAP_PC  = ADDR_WIDTH'(TRAP_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INC);
    localparam logic [63:0] ALIGN_MASK_64 = (64'd1 << IALIGN_BITS) - 64'd1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(ALIGN_MASK_64);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state;

    logic target_unaligned;
    logic redirect_bad;
    logic redirect_ok;
    logic flush;

    // Classify this cycle's control-flow request. A trap outranks a redirect,
    // so a redirect that arrives together with a trap is neither accepted
    // nor reported as misaligned.
    always_comb begin
        target_unaligned = (redirect_target & ALIGN_MASK) != '0;
        redirect_bad     = redirect_valid && !trap_valid && target_unaligned;
        redirect_ok      = redirect_valid && !trap_valid && !target_unaligned;
        flush            = trap_valid || redirect_valid;
    end

    // Sequential link value. The addition wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        pc_next_seq = pc + PC_STEP;
    end

    // Fetch PC. The cases are tested in priority order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (trap_valid || redirect_bad) begin
            pc <= TRAP_PC;
        end else if (redirect_ok) begin
            pc <= redirect_target;
        end else if (!stall && state == S_RUN) begin
            pc <= pc_next_seq;
        end
    end

    // Rejected-target reporting: misaligned is a one-cycle pulse, and
    // bad_addr holds the most recently rejected target.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned <= 1'b0;
            bad_addr   <= '0;
        end else begin
            misaligned <= redirect_bad;
            if (redirect_bad) begin
                bad_addr <= redirect_target;
            end
        end
    end

    // Fetch-to-decode register. A control-flow change flushes it and
    // leaves the stale PC in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_d       <= '0;
            pc_d_valid <= 1'b0;
        end else if (flush) begin
            pc_d_valid <= 1'b0;
        end else if (!stall) begin
            pc_d       <= pc;
            pc_d_valid <= fetch_valid;
        end
    end

    // Run-control FSM. The fetch_valid and halted outputs are registered
    // next to the state so that they always match it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_BOOT;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state       <= S_RUN;
                    fetch_valid <= 1'b1;
                    halted      <= 1'b0;
                end
                S_RUN: begin
                    if (halt && !flush) begin
                        state       <= S_HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (resume || trap_valid || redirect_ok) begin
                        state       <= S_RUN;
                        fetch_valid <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_BOOT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a
// cycle-level reference model.
module tb_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        fetch_valid;
    logic [31:0] pc_d;
    logic        pc_d_valid;
    logic        misaligned;
    logic [31:0] bad_addr;
    logic        halted;

    pc_gen u_dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc),
        .pc_next_seq     (pc_next_seq),
        .fetch_valid     (fetch_valid),
        .pc_d            (pc_d),
        .pc_d_valid      (pc_d_valid),
        .misaligned      (misaligned),
        .bad_addr        (bad_addr),
        .halted          (halted)
    );

    // 8-bit instance, used only to check the address-wrap behaviour.
    logic       r8_valid;
    logic [7:0] r8_target;
    logic [7:0] pc8;
    logic [7:0] pc8_next_seq;
    logic       fv8;
    logic [7:0] pc8_d;
    logic       pc8_d_valid;
    logic       mis8;
    logic [7:0] bad8;
    logic       halted8;

    pc_gen #(.ADDR_WIDTH(8)) u_dut8 (
        .clk             (clk),
        .reset           (reset),
        .stall           (1'b0),
        .redirect_valid  (r8_valid),
        .redirect_target (r8_target),
        .trap_valid      (1'b0),
        .halt            (1'b0),
        .resume          (1'b0),
        .pc              (pc8),
        .pc_next_seq     (pc8_next_seq),
        .fetch_valid     (fv8),
        .pc_d            (pc8_d),
        .pc_d_valid      (pc8_d_valid),
        .misaligned      (mis8),
        .bad_addr        (bad8),
        .halted          (halted8)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state. Mode: 0 = booting, 1 = running, 2 = halted.
    longint unsigned m_pc;
    longint unsigned m_pcd;
    longint unsigned m_bad;
    bit              m_pcdv;
    bit              m_mis;
    int              m_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge, using the inputs currently driven.
    task automatic model_edge();
        bit trap;
        bit redir;
        bit aligned;
        int nmode;
        if (reset) begin
            m_pc = 0; m_pcd = 0; m_pcdv = 0; m_mis = 0; m_bad = 0; m_mode = 0;
            return;
        end
        trap    = trap_valid;
        redir   = redirect_valid;
        aligned = (redirect_target % 4) == 0;

        // Decode stage sees the PC that was fetched before this edge.
        if (trap || redir) m_pcdv = 0;
        else if (!stall) begin m_pcd = m_pc; m_pcdv = (m_mode == 1); end

        m_mis = !trap && redir && !aligned;
        if (m_mis) m_bad = redirect_target;

        nmode = m_mode;
        if (m_mode == 0) nmode = 1;
        else if (m_mode == 1 && halt && !trap && !redir) nmode = 2;
        else if (m_mode == 2 && (resume || trap || (redir && aligned))) nmode = 1;

        if (trap || (redir && !aligned)) m_pc = 64'h100;
        else if (redir) m_pc = redirect_target;
        else if (!stall && m_mode == 1) m_pc = (m_pc + 4) % (64'd1 << 32);
        m_mode = nmode;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},   pc,          32'(m_pc));
        chk({tag, ".seq"},  pc_next_seq, 32'((m_pc + 4) % (64'd1 << 32)));
        chk({tag, ".fv"},   {31'd0, fetch_valid}, {31'd0, m_mode == 1});
        chk({tag, ".hlt"},  {31'd0, halted},      {31'd0, m_mode == 2});
        chk({tag, ".pcd"},  pc_d,        32'(m_pcd));
        chk({tag, ".pcdv"}, {31'd0, pc_d_valid},  {31'd0, m_pcdv});
        chk({tag, ".mis"},  {31'd0, misaligned},  {31'd0, m_mis});
        chk({tag, ".bad"},  bad_addr,    32'(m_bad));
    endtask

    // One clock: update the model from the driven inputs, then sample after the edge.
    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        stall = 0; redirect_valid = 0; redirect_target = 0;
        trap_valid = 0; halt = 0; resume = 0; reset = 0;
    endtask

    initial begin
        idle();
        r8_valid = 0; r8_target = 0;
        m_pc = 0; m_pcd = 0; m_bad = 0; m_pcdv = 0; m_mis = 0; m_mode = 0;
        #1;

        // Reset, then release with no stimulus.
        reset = 1;
        cyc("rst0");
        cyc("rst1");
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        reset = 0;
        cyc("boot");
        chk("boot_pc", pc, 32'h0);
        chk("boot_fv", {31'd0, fetch_valid}, 32'd1);
        chk("boot_pcdv", {31'd0, pc_d_valid}, 32'd0);
        cyc("seq4");
        chk("seq4_pc", pc, 32'h4);
        chk("seq4_pcdv", {31'd0, pc_d_valid}, 32'd1);
        cyc("seq8");
        cyc("seq12");
        chk("seq12_pc", pc, 32'hC);
        chk("seq12_pcd", pc_d, 32'h8);
        cyc("seq16");

        // Stall for three cycles at 0x10, then redirect while still stalled.
        stall = 1;
        for (int i = 0; i < 3; i++) cyc("stall");
        chk("stall_pc", pc, 32'h10);
        chk("stall_pcd", pc_d, 32'hC);
        redirect_valid = 1; redirect_target = 32'h200;
        cyc("stall_redir");
        chk("sredir_pc", pc, 32'h200);
        chk("sredir_pcdv", {31'd0, pc_d_valid}, 32'd0);
        idle();
        cyc("post_redir");

        // A misaligned redirect, back-to-back rejections, and trap over redirect.
        redirect_valid = 1; redirect_target = 32'h202;
        cyc("mis");
        chk("mis_pc", pc, 32'h100);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_bad", bad_addr, 32'h202);
        redirect_target = 32'h305;
        cyc("mis2");
        chk("mis2_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis2_bad", bad_addr, 32'h305);
        idle();
        cyc("mis_end");
        chk("mis_end_pulse", {31'd0, misaligned}, 32'd0);
        chk("mis_hold_bad", bad_addr, 32'h305);
        trap_valid = 1; redirect_valid = 1; redirect_target = 32'h300;
        cyc("trap_redir");
        chk("trap_pc", pc, 32'h100);
        idle();
        cyc("post_trap");

        // Halt at 0x20, resume, then halt again and leave it with a redirect.
        redirect_valid = 1; redirect_target = 32'h20;
        cyc("to20");
        idle();
        halt = 1;
        cyc("halt");
        chk("halt_pc", pc, 32'h24);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
        halt = 0;
        cyc("halt_hold");
        chk("halt_hold_pc", pc, 32'h24);
        resume = 1;
        cyc("resume");
        chk("resume_pc", pc, 32'h24);
        resume = 0;
        cyc("resume_seq");
        chk("resume_seq_pc", pc, 32'h28);
        halt = 1;
        cyc("halt2");
        halt = 0;
        redirect_valid = 1; redirect_target = 32'h80;
        cyc("halt_redir");
        chk("hredir_pc", pc, 32'h80);
        chk("hredir_halted", {31'd0, halted}, 32'd0);
        idle();

        // Reset while halted and while stalled.
        halt = 1;
        cyc("halt3");
        halt = 0; reset = 1;
        cyc("rst_halt");
        chk("rst_halt_pc", pc, 32'h0);
        chk("rst_halt_h", {31'd0, halted}, 32'd0);
        reset = 0;
        cyc("boot2");
        cyc("run2");
        stall = 1;
        cyc("stall2");
        reset = 1;
        cyc("rst_stall");
        chk("rst_stall_pcdv", {31'd0, pc_d_valid}, 32'd0);
        idle();
        cyc("boot3");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            stall          = ($urandom_range(3) == 0);
            trap_valid     = ($urandom_range(15) == 0);
            redirect_valid = ($urandom_range(7) == 0);
            redirect_target = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(31) == 0) redirect_target = 32'hFFFF_FFFC;
            halt           = ($urandom_range(11) == 0);
            resume         = ($urandom_range(3) == 0);
            reset          = ($urandom_range(63) == 0);
            cyc("rnd");
        end
        idle();

        // Address wrap on the 8-bit instance.
        r8_valid = 1; r8_target = 8'hFC;
        cyc("w8a");
        chk("w8_pc_fc", {24'd0, pc8}, 32'hFC);
        chk("w8_seq", {24'd0, pc8_next_seq}, 32'h00);
        r8_valid = 0;
        cyc("w8b");
        chk("w8_wrap", {24'd0, pc8}, 32'h00);
        chk("w8_fv", {31'd0, fv8}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
